// File: rtl/dsp_simd2x_int9xuint8_stim_ref_pkg.sv
// Shared types and constants for the SIMD 2x INT9xUINT8 stimulus/reference slice.
package dsp_simd2x_tb_pkg;

    localparam int unsigned U8_W        = 8;
    localparam int unsigned S9_W        = 9;
    localparam int unsigned PROD_W      = 18;
    localparam int unsigned CORNER_N    = 6;
    localparam int unsigned CORNER_VECS = CORNER_N * CORNER_N * CORNER_N;

    // Galois LFSR taps for x^32+x^22+x^2+x+1, right-shifting form
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CORNER,
        RANDOM,
        DRAIN,
        DONE
    } state_t;

    localparam logic [U8_W-1:0] CORNER_U8 [CORNER_N] = '{
        8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255
    };

    // -256, -255, -1, 0, 1, 255 as 9-bit two's complement
    localparam logic [S9_W-1:0] CORNER_S9 [CORNER_N] = '{
        9'h100, 9'h101, 9'h1FF, 9'h000, 9'h001, 9'h0FF
    };

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // signed 9-bit coefficient times unsigned 8-bit operand, exact in 18 bits
    function automatic logic signed [PROD_W-1:0] mul_s9u8(
        input logic signed [S9_W-1:0] c,
        input logic        [U8_W-1:0] u
    );
        logic signed [PROD_W-1:0] ce;
        logic signed [PROD_W-1:0] ue;
        ce = PROD_W'(c);
        ue = PROD_W'($signed({1'b0, u}));
        return ce * ue;
    endfunction

endpackage

// File: rtl/dsp_simd2x_int9xuint8_stim_ref_if.sv
// Operand, reference and scoreboard-control bundle between the stimulus block and the bench.
interface dsp_simd2x_int9xuint8_stim_ref_if;
    import dsp_simd2x_tb_pkg::*;

    logic [U8_W-1:0]   duv_a;
    logic [U8_W-1:0]   duv_b;
    logic [S9_W-1:0]   duv_coeff;
    logic              duv_valid;
    logic [U8_W-1:0]   a_ref;
    logic [U8_W-1:0]   b_ref;
    logic [S9_W-1:0]   coeff_ref;
    logic [PROD_W-1:0] ca_mul_ref;
    logic [PROD_W-1:0] cb_mul_ref;
    logic              scoreboard_en;
    logic              scoreboard_reset;

    modport master (
        output duv_a, duv_b, duv_coeff, duv_valid,
        output a_ref, b_ref, coeff_ref, ca_mul_ref, cb_mul_ref,
        output scoreboard_en, scoreboard_reset
    );

    modport slave (
        input duv_a, duv_b, duv_coeff, duv_valid,
        input a_ref, b_ref, coeff_ref, ca_mul_ref, cb_mul_ref,
        input scoreboard_en, scoreboard_reset
    );

endinterface

// File: rtl/dsp_simd2x_int9xuint8_stim_ref_delay.sv
// DEPTH-stage valid-qualified delay line; payload only moves with valid,
// so the last stage holds the most recent valid word.
module dsp_simd2x_ref_delay #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    // shift valid every cycle, payload only where the incoming stage is valid
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            if (valid_i) begin
                dat_q[0] <= data_i;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/dsp_simd2x_int9xuint8_stim_ref.sv
// Stimulus generator (corner sweep + LFSR phase) and latency-aligned golden products.
module dsp_simd2x_int9xuint8_stim_ref
    import dsp_simd2x_tb_pkg::*;
#(
    parameter int unsigned DUV_LATENCY  = 3,
    parameter int unsigned RANDOM_COUNT = 65536,
    parameter logic [31:0] LFSR_SEED    = 32'hACE12022
) (
    input  logic clk,
    input  logic aresetn,
    input  logic start,
    output logic busy,
    output logic done,
    dsp_simd2x_int9xuint8_stim_ref_if.master bus
);

    localparam int unsigned PAY_W = 2*U8_W + S9_W + 2*PROD_W;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_b_q, idx_b_d;
    logic [2:0]  idx_a_q, idx_a_d;
    logic [2:0]  idx_c_q, idx_c_d;
    logic [31:0] lfsr_q, lfsr_d;

    logic [U8_W-1:0] duv_a_q, duv_a_d;
    logic [U8_W-1:0] duv_b_q, duv_b_d;
    logic [S9_W-1:0] duv_coeff_q, duv_coeff_d;
    logic            duv_valid_q, duv_valid_d;
    logic            sbr_q, sbr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [PAY_W-1:0] pay_in, pay_out;
    logic             ref_valid;

    // state, phase counter, corner indices and LFSR
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_b_q <= '0;
            idx_a_q <= '0;
            idx_c_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_b_q <= idx_b_d;
            idx_a_q <= idx_a_d;
            idx_c_q <= idx_c_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // phase sequencing and per-phase cycle counting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                state_d = CORNER;
                cnt_d   = '0;
            end
            CORNER: begin
                if (cnt_q == 32'(CORNER_VECS - 1)) begin
                    state_d = (RANDOM_COUNT == 0) ? DRAIN : RANDOM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RANDOM: begin
                if (cnt_q == RANDOM_COUNT - 1) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == DUV_LATENCY - 1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state register instead of trailing it by a cycle.
    always_comb begin
        idx_b_d     = idx_b_q;
        idx_a_d     = idx_a_q;
        idx_c_d     = idx_c_q;
        lfsr_d      = lfsr_q;
        duv_a_d     = duv_a_q;
        duv_b_d     = duv_b_q;
        duv_coeff_d = duv_coeff_q;
        duv_valid_d = 1'b0;
        sbr_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            CLEAR: begin
                sbr_d   = 1'b1;
                busy_d  = 1'b1;
                idx_b_d = '0;
                idx_a_d = '0;
                idx_c_d = '0;
                lfsr_d  = LFSR_SEED;
            end
            CORNER: begin
                busy_d      = 1'b1;
                duv_valid_d = 1'b1;
                duv_a_d     = CORNER_U8[idx_a_q];
                duv_b_d     = CORNER_U8[idx_b_q];
                duv_coeff_d = CORNER_S9[idx_c_q];
                if (idx_b_q == 3'(CORNER_N - 1)) begin
                    idx_b_d = '0;
                    if (idx_a_q == 3'(CORNER_N - 1)) begin
                        idx_a_d = '0;
                        idx_c_d = (idx_c_q == 3'(CORNER_N - 1)) ? '0 : idx_c_q + 3'd1;
                    end else begin
                        idx_a_d = idx_a_q + 3'd1;
                    end
                end else begin
                    idx_b_d = idx_b_q + 3'd1;
                end
            end
            RANDOM: begin
                busy_d      = 1'b1;
                duv_valid_d = 1'b1;
                duv_a_d     = lfsr_q[7:0];
                duv_b_d     = lfsr_q[15:8];
                duv_coeff_d = lfsr_q[24:16];
                lfsr_d      = lfsr_step(lfsr_q);
            end
            DRAIN: begin
                busy_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // registered operand and status outputs
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            duv_a_q     <= '0;
            duv_b_q     <= '0;
            duv_coeff_q <= '0;
            duv_valid_q <= 1'b0;
            sbr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            duv_a_q     <= duv_a_d;
            duv_b_q     <= duv_b_d;
            duv_coeff_q <= duv_coeff_d;
            duv_valid_q <= duv_valid_d;
            sbr_q       <= sbr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pay_in = {duv_a_q, duv_b_q, duv_coeff_q,
                     mul_s9u8(duv_coeff_q, duv_a_q),
                     mul_s9u8(duv_coeff_q, duv_b_q)};

    dsp_simd2x_ref_delay #(
        .DEPTH (DUV_LATENCY),
        .WIDTH (PAY_W)
    ) u_delay (
        .clk     (clk),
        .aresetn (aresetn),
        .valid_i (duv_valid_q),
        .data_i  (pay_in),
        .valid_o (ref_valid),
        .data_o  (pay_out)
    );

    assign bus.duv_a            = duv_a_q;
    assign bus.duv_b            = duv_b_q;
    assign bus.duv_coeff        = duv_coeff_q;
    assign bus.duv_valid        = duv_valid_q;
    assign bus.scoreboard_reset = sbr_q;
    assign bus.scoreboard_en    = ref_valid;
    assign {bus.a_ref, bus.b_ref, bus.coeff_ref, bus.ca_mul_ref, bus.cb_mul_ref} = pay_out;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dsp_simd2x_int9xuint8_stim_ref.sv
// Directed bench for the SIMD 2x INT9xUINT8 stimulus/reference block.
module tb_dsp_simd2x_int9xuint8_stim_ref;

    localparam int unsigned LAT_A = 3;
    localparam int unsigned RC_A  = 16;
    localparam int unsigned LAT_B = 2;
    localparam int unsigned RC_B  = 0;
    localparam int unsigned LAT_C = 3;
    localparam int unsigned RC_C  = 1000;
    localparam int          NA    = 216 + RC_A;
    localparam int          NV    = 216 + RC_C;
    localparam int          HMAX  = 1400;

    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ea [NV];
    logic [7:0]  eb [NV];
    logic [8:0]  ec [NV];
    logic [24:0] run1 [NA];
    logic [24:0] run2 [NA];
    logic [7:0]  ha [HMAX];
    logic [7:0]  hb [HMAX];
    logic [8:0]  hc [HMAX];
    logic        hv [HMAX];

    logic [7:0] cu8 [6] = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
    logic [8:0] cs9 [6] = '{9'h100, 9'h101, 9'h1FF, 9'h000, 9'h001, 9'h0FF};

    always #5 clk = ~clk;

    dsp_simd2x_int9xuint8_stim_ref_if bus_a ();
    dsp_simd2x_int9xuint8_stim_ref_if bus_b ();
    dsp_simd2x_int9xuint8_stim_ref_if bus_c ();

    dsp_simd2x_int9xuint8_stim_ref #(
        .DUV_LATENCY (LAT_A), .RANDOM_COUNT (RC_A), .LFSR_SEED (32'hACE12022)
    ) u_dut_a (
        .clk (clk), .aresetn (aresetn), .start (start_a),
        .busy (busy_a), .done (done_a), .bus (bus_a)
    );

    dsp_simd2x_int9xuint8_stim_ref #(
        .DUV_LATENCY (LAT_B), .RANDOM_COUNT (RC_B), .LFSR_SEED (32'hACE12022)
    ) u_dut_b (
        .clk (clk), .aresetn (aresetn), .start (start_b),
        .busy (busy_b), .done (done_b), .bus (bus_b)
    );

    dsp_simd2x_int9xuint8_stim_ref #(
        .DUV_LATENCY (LAT_C), .RANDOM_COUNT (RC_C), .LFSR_SEED (32'hACE12022)
    ) u_dut_c (
        .clk (clk), .aresetn (aresetn), .start (start_c),
        .busy (busy_c), .done (done_c), .bus (bus_c)
    );

    function automatic logic [17:0] prod(input logic [8:0] c, input logic [7:0] u);
        int p;
        p = $signed(c) * int'(u);
        return 18'(p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // leaves the caller in the CLEAR cycle of the selected instance
    task automatic pulse_start(input int sel);
        @(posedge clk);
        #1;
        if (sel == 0) start_a = 1'b1;
        else if (sel == 1) start_b = 1'b1;
        else start_c = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic build_model();
        logic [31:0] s;
        for (int i = 0; i < 216; i++) begin
            eb[i] = cu8[i % 6];
            ea[i] = cu8[(i / 6) % 6];
            ec[i] = cs9[i / 36];
        end
        s = 32'hACE12022;
        for (int i = 216; i < NV; i++) begin
            ea[i] = s[7:0];
            eb[i] = s[15:8];
            ec[i] = s[24:16];
            s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus_a.duv_valid, bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff} !== 26'd0) begin
            errors++;
            $display("FAIL reset_duv got %h required 0", {bus_a.duv_valid, bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff});
        end
        checks++;
        if ({bus_a.ca_mul_ref, bus_a.cb_mul_ref, bus_a.a_ref, bus_a.b_ref, bus_a.coeff_ref} !== 61'd0) begin
            errors++;
            $display("FAIL reset_ref got %h required 0", {bus_a.ca_mul_ref, bus_a.cb_mul_ref, bus_a.a_ref, bus_a.b_ref, bus_a.coeff_ref});
        end
        checks++;
        if ({bus_a.scoreboard_en, bus_a.scoreboard_reset, busy_a, done_a, busy_c, done_c} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000", {bus_a.scoreboard_en, bus_a.scoreboard_reset, busy_a, done_a, busy_c, done_c});
        end
        aresetn = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_first_vectors();
        int w;
        pulse_start(0);
        checks++;
        if ({bus_a.scoreboard_reset, bus_a.duv_valid, busy_a, bus_a.scoreboard_en} !== 4'b1010) begin
            errors++;
            $display("FAIL clear_cycle got %b required 1010", {bus_a.scoreboard_reset, bus_a.duv_valid, busy_a, bus_a.scoreboard_en});
        end
        step();
        checks++;
        if ({bus_a.duv_valid, bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff, bus_a.scoreboard_reset} !== {1'b1, 8'd0, 8'd0, 9'h100, 1'b0}) begin
            errors++;
            $display("FAIL vec0 got v=%b a=%0d b=%0d c=%h sbr=%b required 1 0 0 100 0", bus_a.duv_valid, bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff, bus_a.scoreboard_reset);
        end
        repeat (3) step();
        checks++;
        if ({bus_a.scoreboard_en, bus_a.ca_mul_ref, bus_a.cb_mul_ref, bus_a.coeff_ref} !== {1'b1, 18'd0, 18'd0, 9'h100}) begin
            errors++;
            $display("FAIL ref0 got en=%b ca=%h cb=%h c=%h required 1 0 0 100", bus_a.scoreboard_en, bus_a.ca_mul_ref, bus_a.cb_mul_ref, bus_a.coeff_ref);
        end
        w = 0;
        while (done_a !== 1'b1 && w < 400) begin
            step();
            w++;
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL first_run_done got %b required 1 within 400 cycles", done_a);
        end
    endtask

    task automatic test_full_stream();
        int  v, r, sb_cnt, done_n;
        logic vexp, eexp;
        sb_cnt = 0;
        done_n = -1;
        pulse_start(0);
        for (int n = 0; n <= 245; n++) begin
            if (n > 0) step();
            v = n - 1;
            r = n - 1 - int'(LAT_A);
            vexp = (v >= 0 && v < NA);
            eexp = (r >= 0 && r < NA);
            checks++;
            if (bus_a.duv_valid !== vexp) begin
                errors++;
                $display("FAIL duv_valid n=%0d got %b required %b", n, bus_a.duv_valid, vexp);
            end
            if (vexp) begin
                run1[v] = {bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff};
                checks++;
                if ({bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff} !== {ea[v], eb[v], ec[v]}) begin
                    errors++;
                    $display("FAIL duv_vec v=%0d got %0d,%0d,%h required %0d,%0d,%h", v, bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff, ea[v], eb[v], ec[v]);
                end
            end
            checks++;
            if (bus_a.scoreboard_en !== eexp) begin
                errors++;
                $display("FAIL sb_en n=%0d got %b required %b", n, bus_a.scoreboard_en, eexp);
            end
            if (eexp) begin
                checks++;
                if ({bus_a.a_ref, bus_a.b_ref, bus_a.coeff_ref, bus_a.ca_mul_ref, bus_a.cb_mul_ref} !==
                    {ea[r], eb[r], ec[r], prod(ec[r], ea[r]), prod(ec[r], eb[r])}) begin
                    errors++;
                    $display("FAIL ref_vec r=%0d got %0d,%0d,%h,%h,%h required %0d,%0d,%h,%h,%h", r,
                             bus_a.a_ref, bus_a.b_ref, bus_a.coeff_ref, bus_a.ca_mul_ref, bus_a.cb_mul_ref,
                             ea[r], eb[r], ec[r], prod(ec[r], ea[r]), prod(ec[r], eb[r]));
                end
            end else if (r >= NA) begin
                checks++;
                if ({bus_a.a_ref, bus_a.coeff_ref, bus_a.cb_mul_ref} !== {ea[NA-1], ec[NA-1], prod(ec[NA-1], eb[NA-1])}) begin
                    errors++;
                    $display("FAIL ref_hold n=%0d got %0d,%h,%h required %0d,%h,%h", n, bus_a.a_ref, bus_a.coeff_ref, bus_a.cb_mul_ref,
                             ea[NA-1], ec[NA-1], prod(ec[NA-1], eb[NA-1]));
                end
            end
            checks++;
            if ({bus_a.scoreboard_reset, busy_a, done_a} !== {n == 0, n <= NA + int'(LAT_A), n > NA + int'(LAT_A)}) begin
                errors++;
                $display("FAIL ctrl n=%0d got sbr/busy/done=%b required %b", n, {bus_a.scoreboard_reset, busy_a, done_a},
                         {n == 0, n <= NA + int'(LAT_A), n > NA + int'(LAT_A)});
            end
            checks++;
            if ({busy_a & done_a, bus_a.scoreboard_reset & bus_a.scoreboard_en} !== 2'b00) begin
                errors++;
                $display("FAIL exclusive n=%0d got %b required 00", n, {busy_a & done_a, bus_a.scoreboard_reset & bus_a.scoreboard_en});
            end
            if (bus_a.scoreboard_en === 1'b1) sb_cnt++;
            if (done_a === 1'b1 && done_n < 0) done_n = n;
            if (n == 34) begin
                checks++;
                if (bus_a.ca_mul_ref !== 18'h30100) begin
                    errors++;
                    $display("FAIL corner_min got %h required 30100", bus_a.ca_mul_ref);
                end
            end
            if (n == 217) begin
                checks++;
                if ({bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff} !== {8'd34, 8'd32, 9'd225}) begin
                    errors++;
                    $display("FAIL rand0_duv got %0d,%0d,%0d required 34,32,225", bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff);
                end
            end
            if (n == 219) begin
                checks++;
                if ({bus_a.ca_mul_ref, bus_a.cb_mul_ref} !== {18'd65025, 18'd65025}) begin
                    errors++;
                    $display("FAIL corner_max got %0d,%0d required 65025,65025", bus_a.ca_mul_ref, bus_a.cb_mul_ref);
                end
            end
            if (n == 220) begin
                checks++;
                if ({bus_a.ca_mul_ref, bus_a.cb_mul_ref} !== {18'd7650, 18'd7200}) begin
                    errors++;
                    $display("FAIL rand0_ref got %0d,%0d required 7650,7200", bus_a.ca_mul_ref, bus_a.cb_mul_ref);
                end
            end
        end
        checks++;
        if (sb_cnt != NA) begin
            errors++;
            $display("FAIL sb_count got %0d required %0d", sb_cnt, NA);
        end
        checks++;
        if (done_n != 236) begin
            errors++;
            $display("FAIL done_rise got n=%0d required n=236", done_n);
        end
    endtask

    task automatic test_random_zero();
        int sb_cnt, v_cnt, done_n;
        sb_cnt = 0;
        v_cnt  = 0;
        done_n = -1;
        pulse_start(1);
        for (int n = 0; n < 300 && done_n < 0; n++) begin
            if (n > 0) step();
            if (bus_b.scoreboard_en === 1'b1) sb_cnt++;
            if (bus_b.duv_valid === 1'b1) v_cnt++;
            if (done_b === 1'b1) done_n = n;
        end
        checks++;
        if (sb_cnt != 216 || v_cnt != 216) begin
            errors++;
            $display("FAIL rc0_count got sb=%0d valid=%0d required 216,216", sb_cnt, v_cnt);
        end
        checks++;
        if (done_n != 216 + int'(LAT_B) + 1) begin
            errors++;
            $display("FAIL rc0_done got n=%0d required n=%0d", done_n, 216 + int'(LAT_B) + 1);
        end
    endtask

    task automatic test_start_ignored();
        int v_cnt, done_n;
        v_cnt  = 0;
        done_n = -1;
        pulse_start(0);
        for (int n = 0; n < 300 && done_n < 0; n++) begin
            if (n > 0) step();
            start_a = (n == 222);
            if (bus_a.duv_valid === 1'b1) v_cnt++;
            if (done_a === 1'b1) done_n = n;
            if (n == 224) begin
                checks++;
                if ({bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff, bus_a.scoreboard_reset} !== {ea[223], eb[223], ec[223], 1'b0}) begin
                    errors++;
                    $display("FAIL ignore_vec got %0d,%0d,%h sbr=%b required %0d,%0d,%h 0", bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff,
                             bus_a.scoreboard_reset, ea[223], eb[223], ec[223]);
                end
            end
        end
        start_a = 1'b0;
        checks++;
        if (v_cnt != NA || done_n != 236) begin
            errors++;
            $display("FAIL ignore_run got valid=%0d done_n=%0d required %0d,236", v_cnt, done_n, NA);
        end
    endtask

    task automatic test_reset_mid_run();
        int diffs, w;
        pulse_start(0);
        repeat (225) step();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy got %b required 1", busy_a);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({bus_a.duv_valid, bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff, bus_a.a_ref, bus_a.b_ref, bus_a.coeff_ref,
             bus_a.ca_mul_ref, bus_a.cb_mul_ref, bus_a.scoreboard_en, bus_a.scoreboard_reset, busy_a, done_a} !== 91'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b a=%0d ca=%h en=%b busy=%b required all zero", bus_a.duv_valid, bus_a.duv_a,
                     bus_a.ca_mul_ref, bus_a.scoreboard_en, busy_a);
        end
        step();
        aresetn = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy_a, done_a, bus_a.duv_valid} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle got %b required 000", {busy_a, done_a, bus_a.duv_valid});
        end
        pulse_start(0);
        for (int n = 1; n <= NA; n++) begin
            step();
            run2[n-1] = {bus_a.duv_a, bus_a.duv_b, bus_a.duv_coeff};
        end
        diffs = 0;
        for (int v = 0; v < NA; v++) begin
            if (run2[v] !== run1[v]) diffs++;
        end
        checks++;
        if (diffs != 0) begin
            errors++;
            $display("FAIL replay got %0d differing vectors required 0", diffs);
        end
        w = 0;
        while (done_a !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL replay_done got %b required 1", done_a);
        end
    endtask

    task automatic test_ideal_duv();
        int tcount, ecount, done_n;
        logic [17:0] dca, dcb;
        tcount = 0;
        ecount = 0;
        done_n = -1;
        pulse_start(2);
        for (int n = 0; n < HMAX && done_n < 0; n++) begin
            if (n > 0) step();
            ha[n] = bus_c.duv_a;
            hb[n] = bus_c.duv_b;
            hc[n] = bus_c.duv_coeff;
            hv[n] = bus_c.duv_valid;
            if (bus_c.scoreboard_reset === 1'b1) begin
                tcount = 0;
                ecount = 0;
            end
            if (bus_c.scoreboard_en === 1'b1) begin
                tcount++;
                if (n >= int'(LAT_C) && hv[n-int'(LAT_C)] === 1'b1) begin
                    dca = prod(hc[n-int'(LAT_C)], ha[n-int'(LAT_C)]);
                    dcb = prod(hc[n-int'(LAT_C)], hb[n-int'(LAT_C)]);
                    if (dca !== bus_c.ca_mul_ref || dcb !== bus_c.cb_mul_ref) ecount++;
                end else begin
                    ecount++;
                end
            end
            if (done_c === 1'b1) done_n = n;
        end
        checks++;
        if (done_n < 0) begin
            errors++;
            $display("FAIL ideal_done got none required done within %0d cycles", HMAX);
        end
        checks++;
        if (ecount != 0) begin
            errors++;
            $display("FAIL ideal_errors got %0d required 0", ecount);
        end
        checks++;
        if (tcount != NV) begin
            errors++;
            $display("FAIL ideal_tests got %0d required %0d", tcount, NV);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_first_vectors();
        test_full_stream();
        test_random_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_ideal_duv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired required completion");
        $fatal(1);
    end

endmodule
